// File: rtl/gap_pkg.sv
// Shared types and width helpers for the global average/max pooling block.
package gap_pkg;

  typedef enum logic [1:0] {
    StAccum,
    StFlush,
    StDrain
  } state_e;

  localparam logic MODE_AVG = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned npix);
    return data_w + clog2(npix);
  endfunction

  function automatic int unsigned prod_w(input int unsigned acc_width, input int unsigned recip);
    return acc_width + clog2(recip) + 1;
  endfunction

endpackage

// File: rtl/gap_scale_sat.sv
// Reciprocal-multiply, round-half-up, arithmetic shift and saturate of one bank sum.
module gap_scale_sat
  import gap_pkg::*;
#(
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RECIP     = 167,
  parameter int unsigned SHIFT     = 15,
  parameter bit          SIGNED_IN = 1'b0
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [DATA_W-1:0] data_o
);

  // One spare bit so the rounding add can never wrap the product.
  localparam int unsigned SUM_W = prod_w(ACC_W, RECIP) + 1;

  localparam logic signed [SUM_W-1:0] RoundV = SUM_W'(64'd1 << (SHIFT - 1));
  localparam logic signed [SUM_W-1:0] MaxV   = SIGNED_IN ?
                                               SUM_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1) :
                                               SUM_W'((64'sd1 <<< DATA_W) - 64'sd1);
  localparam logic signed [SUM_W-1:0] MinV   = SIGNED_IN ?
                                               SUM_W'(-(64'sd1 <<< (DATA_W - 1))) : '0;

  logic signed [SUM_W-1:0] acc_ext, prod, rounded, shifted;

  always_comb begin
    if (SIGNED_IN) acc_ext = SUM_W'($signed(acc_i));
    else           acc_ext = $signed(SUM_W'(acc_i));
    prod    = acc_ext * $signed(SUM_W'(RECIP));
    rounded = prod + RoundV;
    shifted = rounded >>> SHIFT;
    if (shifted > MaxV)      data_o = MaxV[DATA_W-1:0];
    else if (shifted < MinV) data_o = MinV[DATA_W-1:0];
    else                     data_o = shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/gap_multich_unit.sv
// Multi-channel global pooling: accumulates a channel-interleaved stream per channel,
// then drains one average or max result per channel with valid/ready backpressure.
module gap_multich_unit
  import gap_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CH        = 16,
  parameter int unsigned IMG_W     = 14,
  parameter int unsigned IMG_H     = 14,
  parameter int unsigned RECIP     = 167,
  parameter int unsigned SHIFT     = 15,
  parameter bit          SIGNED_IN = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 mode,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic [idx_w(CH)-1:0] m_ch,
  output logic                 m_last
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned ACC_W = acc_w(DATA_W, NPIX);
  localparam int unsigned CH_W  = idx_w(CH);
  localparam int unsigned PIX_W = idx_w(NPIX);

  localparam logic [CH_W-1:0]  LastCh  = CH_W'(CH - 1);
  localparam logic [PIX_W-1:0] LastPix = PIX_W'(NPIX - 1);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    bank_q [CH];
  logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d, rd_ch_q, rd_ch_d, rd_sel;
  logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic                mode_q, mode_d;
  logic                m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;

  logic                beat, bank_we, s_gt;
  logic [ACC_W-1:0]    s_ext, bank_cur, bank_wdata, rd_word;
  logic [DATA_W-1:0]   avg_data, rd_data;

  assign s_ready = (state_q == StAccum);
  // A beat coinciding with clear is dropped.
  assign beat    = s_valid & s_ready & ~clear;

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_ch    = rd_ch_q;
  assign m_last  = m_last_q;

  // Accumulate / max update for the bank entry addressed by ch_cnt.
  always_comb begin
    if (SIGNED_IN) s_ext = ACC_W'($signed(s_data));
    else           s_ext = ACC_W'(s_data);
    bank_cur = bank_q[ch_cnt_q];
    if (SIGNED_IN) s_gt = $signed(s_ext) > $signed(bank_cur);
    else           s_gt = s_ext > bank_cur;
    bank_wdata = s_ext;
    if (pix_cnt_q != '0) begin
      if (mode_q == MODE_MAX) bank_wdata = s_gt ? s_ext : bank_cur;
      else                    bank_wdata = bank_cur + s_ext;
    end
  end

  // Read port looks one channel ahead so the output register reloads on each handshake.
  always_comb begin
    rd_sel = '0;
    if (state_q == StDrain && rd_ch_q != LastCh) rd_sel = rd_ch_q + CH_W'(1);
    rd_word = bank_q[rd_sel];
    rd_data = (mode_q == MODE_MAX) ? rd_word[DATA_W-1:0] : avg_data;
  end

  gap_scale_sat #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .RECIP    (RECIP),
    .SHIFT    (SHIFT),
    .SIGNED_IN(SIGNED_IN)
  ) u_scale (
    .acc_i (rd_word),
    .data_o(avg_data)
  );

  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    pix_cnt_d = pix_cnt_q;
    rd_ch_d   = rd_ch_q;
    mode_d    = mode_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    bank_we   = 1'b0;
    if (clear) begin
      state_d   = StAccum;
      ch_cnt_d  = '0;
      pix_cnt_d = '0;
      rd_ch_d   = '0;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end else begin
      case (state_q)
        StAccum: begin
          if (beat) begin
            bank_we = 1'b1;
            if (pix_cnt_q == '0 && ch_cnt_q == '0) mode_d = mode;
            if (ch_cnt_q == LastCh) begin
              ch_cnt_d = '0;
              if (pix_cnt_q == LastPix) begin
                pix_cnt_d = '0;
                state_d   = StFlush;
              end else begin
                pix_cnt_d = pix_cnt_q + PIX_W'(1);
              end
            end else begin
              ch_cnt_d = ch_cnt_q + CH_W'(1);
            end
          end
        end
        StFlush: begin
          state_d   = StDrain;
          rd_ch_d   = '0;
          m_valid_d = 1'b1;
          m_data_d  = rd_data;
          m_last_d  = (LastCh == '0);
        end
        StDrain: begin
          if (m_valid_q && m_ready) begin
            if (rd_ch_q == LastCh) begin
              state_d   = StAccum;
              rd_ch_d   = '0;
              m_valid_d = 1'b0;
              m_last_d  = 1'b0;
            end else begin
              rd_ch_d  = rd_ch_q + CH_W'(1);
              m_data_d = rd_data;
              m_last_d = ((rd_ch_q + CH_W'(1)) == LastCh);
            end
          end
        end
        default: state_d = StAccum;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StAccum;
      ch_cnt_q  <= '0;
      pix_cnt_q <= '0;
      rd_ch_q   <= '0;
      mode_q    <= MODE_AVG;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      rd_ch_q   <= rd_ch_d;
      mode_q    <= mode_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CH; i++) bank_q[i] <= '0;
    end else if (bank_we) begin
      bank_q[ch_cnt_q] <= bank_wdata;
    end
  end

endmodule

// File: tb/tb_gap_multich_unit.sv
// Self-checking bench: table-driven frames with a result scoreboard, plus clear,
// async-reset and signed-input sequences.
module tb_gap_multich_unit;

  localparam int NPIX = 196;
  localparam int NCH  = 16;
  localparam int SCH  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clear, mode, s_valid, s_ready, m_valid, m_ready, m_last;
  logic [7:0] s_data, m_data;
  logic [3:0] m_ch;

  logic       smode, ss_valid, ss_ready, sm_valid, sm_ready, sm_last, sclear;
  logic [7:0] ss_data, sm_data;
  logic [1:0] sm_ch;

  gap_multich_unit u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .mode   (mode),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_ch   (m_ch),
    .m_last (m_last)
  );

  gap_multich_unit #(
    .CH       (SCH),
    .SIGNED_IN(1'b1)
  ) u_sdut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (sclear),
    .mode   (smode),
    .s_valid(ss_valid),
    .s_ready(ss_ready),
    .s_data (ss_data),
    .m_valid(sm_valid),
    .m_ready(sm_ready),
    .m_data (sm_data),
    .m_ch   (sm_ch),
    .m_last (sm_last)
  );

  typedef struct {
    string name;
    logic  md;
    int    pat;
    bit    tog;
    bit    bp;
    int    base;
    int    step;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] ch;
    logic       last;
  } exp_t;

  typedef struct {
    logic md;
    int   pat;
    int   e[SCH];
  } svec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   beat_cyc = 0;
  bit   lat_armed = 0, post_last = 0, held = 0, mon_en = 1, bp_en = 0;
  logic rdy_level = 1'b1;
  logic [7:0] hd;
  logic [3:0] hc;
  logic       hl;
  exp_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sample(input int pat, input int arg, input int pix,
                                        input int ch);
    int v;
    case (pat)
      0:       v = arg;
      1:       v = ch * 10;
      2:       v = (pix % 2 == 0) ? 2 * (ch + 10) : 0;
      3: begin
        v = (200 - ch) - ((pix > arg) ? pix - arg : arg - pix);
        if (v < 0) v = 0;
      end
      default: v = 0;
    endcase
    return 8'(v);
  endfunction

  function automatic logic [7:0] ssample(input int pat, input int pix, input int ch);
    int v;
    if (pat == 0) v = (ch == 0) ? -128 : (ch == 1) ? 127 : ((pix % 2 == 1) ? -1 : 0);
    else          v = (ch == 0) ? ((pix % 2 == 1) ? 5 : -100) : (ch == 1) ? -7 : -50 + pix % 10;
    return 8'(v);
  endfunction

  // m_ready driver
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp_en ? 1'($urandom_range(0, 1)) : rdy_level;
    end
  end

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (post_last) begin
        check("s_ready_after_drain", int'(s_ready), 1);
        check("m_valid_after_drain", int'(m_valid), 0);
        post_last = 0;
      end
      if (m_valid) begin
        check("s_ready_low_in_drain", int'(s_ready), 0);
        if (lat_armed) begin
          check("first_valid_latency", cyc - beat_cyc, 2);
          lat_armed = 0;
        end
        if (held) begin
          check("hold_data", int'(m_data), int'(hd));
          check("hold_ch", int'(m_ch), int'(hc));
          check("hold_last", int'(m_last), int'(hl));
        end
        if (m_ready) begin
          held = 0;
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got ch %0d data %0d, expected none", m_ch, m_data);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("result_data", int'(m_data), int'(e.data));
            check("result_ch", int'(m_ch), int'(e.ch));
            check("result_last", int'(m_last), int'(e.last));
            if (e.last) post_last = 1;
          end
        end else begin
          held = 1;
          hd   = m_data;
          hc   = m_ch;
          hl   = m_last;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!s_ready) check("s_ready_timeout", int'(s_ready), 1);
  endtask

  task automatic beat(input logic [7:0] d, input logic md, input bit last);
    wait_ready();
    s_valid  = 1'b1;
    s_data   = d;
    mode     = md;
    beat_cyc = cyc;
    if (last) lat_armed = 1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int pat, input int arg, input logic md0, input bit tog);
    for (int p = 0; p < NPIX; p++) begin
      for (int c = 0; c < NCH; c++) begin
        logic md;
        if ($urandom_range(0, 7) == 0) begin
          @(posedge clk);
          #1;
        end
        md = (tog && (p != 0 || c != 0)) ? 1'($urandom_range(0, 1)) : md0;
        beat(sample(pat, arg, p, c), md, (p == NPIX - 1) && (c == NCH - 1));
      end
    end
  endtask

  task automatic push_exp(input int base, input int step);
    for (int c = 0; c < NCH; c++) begin
      exp_t e;
      e.data = 8'(base + step * c);
      e.ch   = 4'(c);
      e.last = (c == NCH - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_sb_empty(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_results_remaining"}, sb_q.size(), 0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  vec_t  vecs[7];
  svec_t svecs[2];

  initial begin
    vecs[0] = '{"avg_const100", 1'b0, 0, 0, 0, 100, 0};
    vecs[1] = '{"avg_const255", 1'b0, 0, 0, 0, 255, 0};
    vecs[2] = '{"avg_ch_x10",   1'b0, 1, 0, 1, 0, 10};
    vecs[3] = '{"max_ramp_tog", 1'b1, 3, 1, 1, 200, -1};
    vecs[4] = '{"avg_alt_tog",  1'b0, 2, 1, 1, 10, 1};
    vecs[5] = '{"max_alt",      1'b1, 2, 0, 0, 20, 2};
    vecs[6] = '{"avg_const0",   1'b0, 0, 0, 0, 0, 0};
    svecs[0] = '{1'b0, 0, '{-128, 127, 0}};
    svecs[1] = '{1'b1, 1, '{5, -7, -41}};

    rst_n = 1'b0; clear = 1'b0; mode = 1'b0; s_valid = 1'b0; s_data = '0;
    smode = 1'b0; ss_valid = 1'b0; ss_data = '0; sm_ready = 1'b1; sclear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_s_ready", int'(s_ready), 1);
    check("reset_m_valid", int'(m_valid), 0);
    check("reset_m_data", int'(m_data), 0);
    check("reset_m_ch", int'(m_ch), 0);
    check("reset_m_last", int'(m_last), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      int arg;
      bp_en = vecs[i].bp;
      arg   = (vecs[i].pat == 3) ? int'($urandom_range(0, NPIX - 1)) : vecs[i].base;
      push_exp(vecs[i].base, vecs[i].step);
      send_frame(vecs[i].pat, arg, vecs[i].md, vecs[i].tog);
      wait_sb_empty(vecs[i].name);
    end
    bp_en = 0;

    // Abort a frame at pixel 57 channel 3; the beat alongside clear is dropped.
    for (int i = 0; i < 57 * NCH + 3; i++) beat(8'd200, 1'b1, 0);
    s_valid = 1'b1; s_data = 8'd200; clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; s_valid = 1'b0;
    check("clear_s_ready", int'(s_ready), 1);
    check("clear_m_valid", int'(m_valid), 0);
    push_exp(50, 0);
    send_frame(0, 50, 1'b0, 0);
    wait_sb_empty("after_clear");

    // Async reset while a result is stalled.
    mon_en = 0; rdy_level = 1'b0;
    send_frame(0, 77, 1'b0, 0);
    begin
      int n = 0;
      while (!m_valid && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("stall_m_valid", int'(m_valid), 1);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_m_valid", int'(m_valid), 0);
    check("async_rst_m_data", int'(m_data), 0);
    check("async_rst_m_ch", int'(m_ch), 0);
    check("async_rst_m_last", int'(m_last), 0);
    check("async_rst_s_ready", int'(s_ready), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1; rdy_level = 1'b1; lat_armed = 0; held = 0; post_last = 0;
    begin
      int seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (m_valid) seen++;
      end
      check("no_valid_after_reset", seen, 0);
    end

    // Signed-input instance, three channels.
    for (int v = 0; v < 2; v++) begin
      for (int p = 0; p < NPIX; p++) begin
        for (int c = 0; c < SCH; c++) begin
          int n = 0;
          while (!ss_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
          end
          ss_valid = 1'b1;
          ss_data  = ssample(svecs[v].pat, p, c);
          smode    = (p == 0 && c == 0) ? svecs[v].md : ~svecs[v].md;
          @(posedge clk);
          #1;
          ss_valid = 1'b0;
        end
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!sm_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < SCH; k++) begin
          check("signed_valid", int'(sm_valid), 1);
          check("signed_data", int'($signed(sm_data)), svecs[v].e[k]);
          check("signed_ch", int'(sm_ch), k);
          check("signed_last", int'(sm_last), int'(k == SCH - 1));
          @(negedge clk);
        end
        check("signed_ready_after", int'(ss_ready), 1);
      end
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gap_multich_unit.md
Name: gap_multich_unit

Overview:
- Multi-channel global pooling block: consumes a channel-interleaved feature-map stream (pixel 0 ch0..chN-1, pixel 1 ch0.., ...) and reduces each channel over IMG_W*IMG_H pixels to one value.
- Two modes: average (reciprocal-multiply, rounded, saturated) and max.
- Sits between the last conv/activation stage and the FC classifier.
- Valid/ready on both sides; per-channel results are drained serially with backpressure.

Parameters:
DATA_W, 8, input/output sample width
CH, 16, channels per pixel (>=1)
IMG_W, 14, feature-map width
IMG_H, 14, feature-map height
RECIP, 167, fixed-point reciprocal of IMG_W*IMG_H, i.e. round(2^SHIFT/(IMG_W*IMG_H))
SHIFT, 15, reciprocal fraction bits
SIGNED_IN, 0, 1 = samples are two's complement; 0 = unsigned

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
clear  in  1  synchronous abort: discard partial frame, return to ACCUM with empty bank
mode  in  1  0 = average, 1 = max; sampled on first accepted beat of a frame
s_valid  in  1  input sample valid
s_ready  out  1  block can accept a sample
s_data  in  DATA_W  input sample
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_data  out  DATA_W  pooled result
m_ch  out  clog2(CH) (min 1)  channel index of m_data
m_last  out  1  high with the result for channel CH-1

Behaviour:
- Reset values: s_ready=1, m_valid=0, m_data=0, m_ch=0, m_last=0; counters zero; bank cleared; state ACCUM.
- ACC_W = DATA_W + clog2(IMG_W*IMG_H). Bank: CH accumulators of ACC_W bits, plus ch_cnt (0..CH-1) and pix_cnt (0..IMG_W*IMG_H-1).
- States: ACCUM, FLUSH, DRAIN.
- ACCUM:
  - s_ready=1. Each handshake (s_valid & s_ready) updates bank[ch_cnt]:
    - Avg mode: bank[ch_cnt] += sign/zero-extended s_data.
    - Max mode: bank[ch_cnt] = max(bank, s_data), using signed compare when SIGNED_IN=1.
  - Pixel 0 loads the bank entry instead of accumulating, so no separate clear pass is needed.
  - ch_cnt wraps at CH-1, then pix_cnt increments.
  - On the handshake for pix_cnt=last and ch_cnt=CH-1, go to FLUSH; both counters wrap to 0.
- FLUSH: one cycle; s_ready=0; lets the final bank write settle. Then go to DRAIN with rd_ch=0.
- DRAIN:
  - s_ready=0. Output register is loaded from bank[rd_ch].
  - m_valid rises exactly 2 cycles after the final accepted input beat.
  - On each m_valid & m_ready: advance rd_ch and reload the output register in the same cycle. With m_ready held high this gives one result per cycle.
  - m_data, m_ch and m_last stay stable while m_valid & !m_ready.
  - After the ch CH-1 handshake: m_valid=0 next cycle, return to ACCUM, s_ready=1 that same cycle.
- Average arithmetic:
  - prod = bank * RECIP, computed full-width at ACC_W+clog2(RECIP)+1 bits.
  - Add 2^(SHIFT-1) for round-half-up, then arithmetic shift right by SHIFT.
  - Saturate to the DATA_W range: unsigned 0..2^DATA_W-1, or signed -2^(DATA_W-1)..2^(DATA_W-1)-1.
- Max arithmetic: output is bank[rd_ch] unchanged; it already fits in DATA_W.
- clear:
  - Highest priority after reset, in any state.
  - Next cycle: state ACCUM, counters 0, m_valid=0, s_ready=1.
  - A beat presented in the same cycle as clear is dropped.
- Mode changes mid-frame are ignored; the latched mode applies to the whole frame and its drain.
- Reset mid-frame or mid-drain behaves identically to power-up reset; no partial output is emitted.

Decomposition:
- Package gap_pkg holds:
  - clog2 function;
  - state enum (ACCUM/FLUSH/DRAIN);
  - ACC_W/PROD_W derivation;
  - MODE_AVG/MODE_MAX constants.
- Sub-module gap_scale_sat: combinational multiply, round, shift and saturate.
  - Parameters: ACC_W, DATA_W, RECIP, SHIFT, SIGNED_IN.
  - Unit-testable on its own; the main block instantiates it once on the bank read path.

Test Plan:
1. Defaults, avg, all samples of every channel = 100 → 16 results of 100, m_ch 0..15, m_last only on ch15; first m_valid 2 cycles after the last beat.
2. Avg, all samples = 255 → sum 49980, product with rounding gives 255 (no overflow). Channel c = c*10 → results c*10 exactly.
3. Max mode, ch k receives a ramp peaking at 200-k at a random pixel → outputs 200-k. Toggle mode mid-frame → no effect.
4. SIGNED_IN=1, avg, ch0 all -128, ch1 all 127, ch2 alternating -1/0 → -128, 127, and round(-98/196) = 0 (round-half-up).
5. Random m_ready backpressure during drain → outputs stable while stalled, no loss or duplication; s_ready=0 throughout drain; s_ready=1 the cycle after the ch15 handshake.
6. Assert clear mid-frame at pixel 57 ch3, then send a full all-50 frame → results all 50. Async rst_n mid-drain → all outputs at reset values, no further m_valid.
